dw_shifter_pipe: RTL
====================

DW_SHIFTER_PIPE -- requirements
Module: dw_shifter_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data path width (2..256).
REQ-002 SHALL have parameter SH_WIDTH, default 5, shift-amount width (1..8).
REQ-003 SHALL have parameter PIPE_STAGES, default 2, register stages from input to output (1..SH_WIDTH).
REQ-004 SHALL have parameter PAD, default 0, fill bit for vacated positions (0 or 1).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-006 SHALL have in_valid  input  1  request valid.
REQ-007 SHALL have in_ready  output  1  request accepted when in_valid && in_ready.
REQ-008 SHALL have data_in  input  DATA_WIDTH  operand.
REQ-009 SHALL have sh  input  SH_WIDTH  shift amount.
REQ-010 SHALL have sh_tc  input  1  1 = sh is two's complement (negative = right), 0 = unsigned (always left).
REQ-011 SHALL have data_tc  input  1  1 = operand signed (sign fill on arithmetic right shift).
REQ-012 SHALL have sh_mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 bypass.
REQ-013 SHALL have out_valid  output  1  result valid.
REQ-014 SHALL have out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 SHALL have data_out  output  DATA_WIDTH  result.
REQ-016 SHALL have lost  output  1  at least one 1-bit shifted out of the word.

Function
REQ-017 Direction/magnitude SHALL be: left by sh if sh_tc=0 or sh MSB=0; otherwise right by the two's-complement magnitude of sh (e.g. 4'b1000 = right by 8).
REQ-018 Rotate SHALL use magnitude modulo DATA_WIDTH; lost=0.
REQ-019 Logical SHALL fill vacated bits with PAD; magnitude >= DATA_WIDTH gives all PAD.
REQ-020 Arithmetic left SHALL equal logical left; arithmetic right SHALL fill with data_in MSB if data_tc=1, else PAD; magnitude >= DATA_WIDTH gives all fill.
REQ-021 Bypass SHALL give data_out = data_in, lost=0.
REQ-022 lost SHALL be the OR of all operand bits discarded past either word end; fill bits SHALL never set it.
REQ-023 Shift decomposition SHALL be log2 stages (one per sh bit), split evenly across PIPE_STAGES registers; sh, mode, tc and fill bit travel with the data.
REQ-024 Latency SHALL be exactly PIPE_STAGES cycles from acceptance to out_valid with no back-pressure; throughput one result per cycle.
REQ-025 Pipeline SHALL advance when adv = !out_valid || out_ready; in_ready SHALL equal adv (0 while rst=1); all stages hold when adv=0.
REQ-026 Each stage SHALL carry a valid bit; a cycle with adv=1 and no acceptance SHALL insert a bubble.
REQ-027 While out_valid=1 && out_ready=0, data_out and lost SHALL remain stable.
REQ-028 Results SHALL be returned in acceptance order; no request SHALL be dropped or duplicated.
REQ-029 Simultaneous accept and output consumption in one cycle SHALL both complete.
REQ-030 Inputs other than in_valid/out_ready SHALL be don't-care when in_valid=0.

Reset
REQ-031 On rst=1 at a clk edge all stage valid bits, out_valid, data_out and lost SHALL become 0.
REQ-032 Reset mid-operation SHALL discard all in-flight requests; no out_valid SHALL appear for them.
REQ-033 First request SHALL be accepted in the first cycle after rst deasserts.

Verification (DATA_WIDTH=8, SH_WIDTH=4, PIPE_STAGES=2, PAD=0, out_ready=1 unless stated)
REQ-034 Rotate: data_in=0x81, sh=1, sh_tc=0, mode=00 -> out_valid 2 cycles later, data_out=0x03, lost=0.
REQ-035 Arithmetic right: data_in=0x90, sh=4'b1110, sh_tc=1, data_tc=1, mode=10 -> data_out=0xE4, lost=0; same with data_tc=0 -> 0x24.
REQ-036 Logical left overflow: data_in=0xF0, sh=4, mode=01 -> data_out=0x00, lost=1; sh=12 -> 0x00, lost=1; rotate sh=12 on 0x12 -> 0x21.
REQ-037 Back-pressure: accept 0x01,0x02,0x04 (mode 11) on consecutive cycles, out_ready=0 for 3 cycles -> in_ready=0 once out_valid=1, data_out held 0x01; after release outputs 0x01,0x02,0x04 in order, one per cycle.
REQ-038 Reset: accept two requests, assert rst one cycle later -> out_valid stays 0, in_ready=1 the cycle after rst deasserts, next request (0x81, rotate sh=1) returns 0x03 after 2 cycles.

Source files
------------

// File: rtl/dw_shifter_pipe_if.sv
// Request/response bundle for the pipelined barrel shifter.
// The master side issues shift requests and consumes results; the slave side is the shifter.
interface dw_shifter_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SH_WIDTH   = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic [SH_WIDTH-1:0]   sh;
    logic                  sh_tc;
    logic                  data_tc;
    logic [1:0]            sh_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  lost;

    modport master (
        output in_valid, data_in, sh, sh_tc, data_tc, sh_mode, out_ready,
        input  in_ready, out_valid, data_out, lost
    );

    modport slave (
        input  in_valid, data_in, sh, sh_tc, data_tc, sh_mode, out_ready,
        output in_ready, out_valid, data_out, lost
    );
endinterface

// File: rtl/dw_shifter_pipe.sv
// Pipelined barrel shifter: rotate / logical / arithmetic / bypass.
// One log2 shift step per shift-amount bit, the steps spread evenly over
// PIPE_STAGES registers. Direction, magnitude, mode and fill bit are decoded
// once at the input and travel with the data. A per-bit "operand" mask also
// travels with the data so that only genuine operand bits, never fill bits,
// can raise lost when they fall off either end of the word.
module dw_shifter_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int SH_WIDTH    = 5,
    parameter int PIPE_STAGES = 2,
    parameter int PAD         = 0
) (
    input logic             clk,
    input logic             rst,
    dw_shifter_pipe_if.slave bus
);

    localparam int unsigned           DW      = DATA_WIDTH;
    localparam int unsigned           SW      = SH_WIDTH;
    localparam int unsigned           PS      = PIPE_STAGES;
    localparam logic                  PAD_BIT = (PAD != 0);
    localparam logic [DATA_WIDTH-1:0] ONES    = '1;

    typedef enum logic [1:0] {
        MODE_ROT   = 2'b00,
        MODE_LOG   = 2'b01,
        MODE_ARITH = 2'b10,
        MODE_BYP   = 2'b11
    } mode_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] mask;
        logic                  lost;
        logic                  left;
        logic [SH_WIDTH-1:0]   mag;
        mode_t                 mode;
        logic                  fill;
    } stage_t;

    // One log2 step: shift by 2**k when magnitude bit k is set.
    function automatic stage_t step(input stage_t s, input int unsigned k);
        stage_t                  r;
        logic [SH_WIDTH-1:0]     m;
        int unsigned             amt;
        int unsigned             rot;
        logic [2*DATA_WIDTH-1:0] dbl;
        logic [DATA_WIDTH-1:0]   drop;
        logic [DATA_WIDTH-1:0]   fillv;
        r    = s;
        m    = s.mag >> k;
        amt  = 32'd1 << k;
        rot  = amt % DW;
        dbl  = {s.data, s.data};
        drop = '0;
        fillv = '0;
        if (m[0]) begin
            case (s.mode)
                MODE_ROT: begin
                    if (s.left) begin
                        dbl    = dbl << rot;
                        r.data = dbl[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        dbl    = dbl >> rot;
                        r.data = dbl[DATA_WIDTH-1:0];
                    end
                end
                MODE_LOG, MODE_ARITH: begin
                    if (amt >= DW) begin
                        r.lost = s.lost | (|(s.data & s.mask));
                        r.data = {DATA_WIDTH{s.fill}};
                        r.mask = '0;
                    end else if (s.left) begin
                        drop   = ~(ONES >> amt);
                        fillv  = s.fill ? ~(ONES << amt) : '0;
                        r.lost = s.lost | (|(s.data & s.mask & drop));
                        r.data = (s.data << amt) | fillv;
                        r.mask = s.mask << amt;
                    end else begin
                        drop   = ~(ONES << amt);
                        fillv  = s.fill ? ~(ONES >> amt) : '0;
                        r.lost = s.lost | (|(s.data & s.mask & drop));
                        r.data = (s.data >> amt) | fillv;
                        r.mask = s.mask >> amt;
                    end
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    // Apply the log2 steps owned by register stage idx.
    function automatic stage_t run_stage(input stage_t s, input int unsigned idx);
        stage_t cur;
        cur = s;
        for (int unsigned k = 0; k < SW; k++) begin
            if ((k * PS) / SW == idx) cur = step(cur, k);
        end
        return cur;
    endfunction

    stage_t pipe [PIPE_STAGES];
    stage_t nxt  [PIPE_STAGES];
    stage_t in_stage;
    logic   adv;
    logic   accept;

    assign adv           = !pipe[PS-1].valid || bus.out_ready;
    assign bus.in_ready  = adv && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = pipe[PS-1].valid;
    assign bus.data_out  = pipe[PS-1].data;
    assign bus.lost      = pipe[PS-1].lost;

    // Decode direction, magnitude and fill bit of the incoming request.
    always_comb begin
        in_stage       = '0;
        in_stage.valid = accept;
        in_stage.data  = bus.data_in;
        in_stage.mask  = ONES;
        in_stage.lost  = 1'b0;
        in_stage.left  = !bus.sh_tc || !bus.sh[SH_WIDTH-1];
        in_stage.mag   = in_stage.left ? bus.sh : -bus.sh;
        in_stage.mode  = mode_t'(bus.sh_mode);
        in_stage.fill  = (in_stage.mode == MODE_ARITH && !in_stage.left && bus.data_tc)
                         ? bus.data_in[DATA_WIDTH-1] : PAD_BIT;
    end

    // Combinational shift work feeding each pipeline register.
    always_comb begin
        nxt[0] = run_stage(in_stage, 0);
        for (int unsigned r = 1; r < PS; r++) begin
            nxt[r] = run_stage(pipe[r-1], r);
        end
    end

    // Pipeline registers: clear on reset, advance together or hold together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < PS; r++) pipe[r] <= '0;
        end else if (adv) begin
            for (int unsigned r = 0; r < PS; r++) pipe[r] <= nxt[r];
        end
    end

endmodule
